// File: rtl/key_scan.sv
// 4x4 matrix keypad scanner: walks a single active-low row, samples the synchronized
// columns on a slow tick, debounces press and release, and strobes one code per press.
module key_scan #(
  parameter int SCAN_DIV  = 11999,
  parameter int DEB_TICKS = 20
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic [3:0] COL,
  output logic [3:0] ROW,
  output logic [3:0] KEY_Value,
  output logic       Value_en
);
  localparam int DW = $clog2(SCAN_DIV + 1);
  localparam int CW = $clog2(DEB_TICKS + 1);
  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV);
  localparam logic [CW-1:0] DEB_MAX = CW'(DEB_TICKS);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  state_t        state;
  logic [DW-1:0] div;
  logic [CW-1:0] deb_cnt;
  logic [CW-1:0] rel_cnt;
  logic [3:0]    col_s1, col_s;
  logic [3:0]    code;
  logic [3:0]    samp;
  logic [1:0]    r_idx, c_idx;
  logic          tick, key_hit;

  assign tick = (div == DIV_MAX);
  assign samp = {r_idx, c_idx};

  // ROW is one-hot low, so the last low bit found is the only one.
  always_comb begin
    r_idx = 2'd0;
    for (int i = 0; i < 4; i++)
      if (!ROW[i]) r_idx = 2'(i);
  end

  // Only a single low column is a key; none or several is treated as no key.
  always_comb begin
    key_hit = 1'b0;
    c_idx   = 2'd0;
    case (col_s)
      4'b1110: begin key_hit = 1'b1; c_idx = 2'd0; end
      4'b1101: begin key_hit = 1'b1; c_idx = 2'd1; end
      4'b1011: begin key_hit = 1'b1; c_idx = 2'd2; end
      4'b0111: begin key_hit = 1'b1; c_idx = 2'd3; end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      col_s1    <= 4'hF;
      col_s     <= 4'hF;
      div       <= '0;
      state     <= SCAN;
      ROW       <= 4'b1110;
      code      <= 4'h0;
      deb_cnt   <= '0;
      rel_cnt   <= '0;
      KEY_Value <= 4'h0;
      Value_en  <= 1'b0;
    end else begin
      col_s1   <= COL;
      col_s    <= col_s1;
      div      <= tick ? '0 : div + 1'b1;
      Value_en <= 1'b0;
      if (tick) begin
        case (state)
          SCAN: begin
            if (key_hit) begin
              code    <= samp;
              deb_cnt <= CW'(1);
              state   <= DEBOUNCE;
            end else begin
              ROW <= {ROW[2:0], ROW[3]};
            end
          end
          DEBOUNCE: begin
            // The detection tick already counted as the first sample.
            if (key_hit && samp == code) begin
              if (deb_cnt == DEB_MAX - 1'b1) begin
                KEY_Value <= code;
                Value_en  <= 1'b1;
                deb_cnt   <= '0;
                rel_cnt   <= '0;
                state     <= HELD;
              end else begin
                deb_cnt <= deb_cnt + 1'b1;
              end
            end else begin
              deb_cnt <= '0;
              ROW     <= {ROW[2:0], ROW[3]};
              state   <= SCAN;
            end
          end
          HELD: begin
            // ROW stays on the pressed row so the release is seen on that row.
            if (col_s == 4'hF) begin
              if (rel_cnt == DEB_MAX - 1'b1) begin
                rel_cnt <= '0;
                state   <= SCAN;
              end else begin
                rel_cnt <= rel_cnt + 1'b1;
              end
            end else begin
              rel_cnt <= '0;
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_key_scan.sv
// Bench for key_scan: keypad model shorts COL[c] to ROW[r]; strobes are checked
// against a scoreboard of expected codes and arrival cycles.
module tb_key_scan;
  localparam int SD = 9;
  localparam int DT = 3;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [3:0]  key_value;
  logic        value_en;
  logic [15:0] keys = '0;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct { logic [3:0] code; int at; } exp_t;
  exp_t       sbq[$];
  exp_t       pop_e;
  exp_t       push_e;
  logic [3:0] kv_exp = 4'h0;
  logic       prev_en = 1'b0;

  typedef struct { logic [15:0] keys; int r; bit single; logic [3:0] code; } vec_t;
  vec_t vt[6];

  key_scan #(.SCAN_DIV(SD), .DEB_TICKS(DT)) dut (
    .CLK(clk), .nRST(nrst), .COL(col), .ROW(row),
    .KEY_Value(key_value), .Value_en(value_en)
  );

  always #5 clk = ~clk;

  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row[r]) col[c] = 1'b0;
  end

  // cyc = number of rising edges since reset was released
  always @(posedge clk or negedge nrst)
    if (!nrst) cyc <= 0;
    else       cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] rowv(input int idx);
    logic [3:0] v;
    v = 4'hF;
    v[idx] = 1'b0;
    return v;
  endfunction

  task automatic wait_cyc(input int n);
    int guard = 0;
    while (cyc != n && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != n) chk("wait_timeout", cyc, n);
  endtask

  task automatic chk_row(input int n, input int idx);
    wait_cyc(n);
    chk("row", row, rowv(idx));
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
  endtask

  // Monitor: reset values, strobe code/cycle from the scoreboard, KEY_Value hold.
  always begin
    @(posedge clk);
    #3;
    if (!nrst) begin
      chk("rst_row", row, 4'b1110);
      chk("rst_en", value_en, 0);
      chk("rst_key", key_value, 0);
      kv_exp  = 4'h0;
      prev_en = 1'b0;
    end else begin
      if (value_en) begin
        chk("en_back_to_back", prev_en, 0);
        if (sbq.size() == 0) begin
          chk("unexpected_strobe", value_en, 0);
        end else begin
          pop_e = sbq.pop_front();
          chk("strobe_code", key_value, pop_e.code);
          chk("strobe_cycle", cyc, pop_e.at);
          kv_exp = pop_e.code;
        end
      end else begin
        chk("key_hold", key_value, kv_exp);
      end
      prev_en = value_en;
    end
  end

  initial begin
    // keys bit r*4+c; row r is driven on cycles [40+10r, 50+10r)
    vt[0] = '{16'h0200, 2, 1'b1, 4'h9};
    vt[1] = '{16'h0001, 0, 1'b1, 4'h0};
    vt[2] = '{16'h0040, 1, 1'b1, 4'h6};
    vt[3] = '{16'h8000, 3, 1'b1, 4'hF};
    vt[4] = '{16'h0090, 1, 1'b0, 4'h0};
    vt[5] = '{16'h0008, 0, 1'b1, 4'h3};

    // idle scan: one rotation per 10 cycles
    do_reset();
    for (int n = 1; n <= 200; n++) chk_row(n, (n / 10) % 4);
    chk("sb_empty_idle", sbq.size(), 0);

    // table: press in row r's window, hold 300 cycles, release
    for (int i = 0; i < 6; i++) begin
      int r;
      r = vt[i].r;
      keys = '0;
      do_reset();
      wait_cyc(41 + 10*r);
      keys = vt[i].keys;
      if (vt[i].single) begin
        push_e.code = vt[i].code;
        push_e.at   = 70 + 10*r;
        sbq.push_back(push_e);
      end
      chk_row(200 + 10*r, vt[i].single ? r : ((200 + 10*r) / 10) % 4);
      wait_cyc(341 + 10*r);
      keys = '0;
      chk_row(379 + 10*r, vt[i].single ? r : ((379 + 10*r) / 10) % 4);
      chk_row(380 + 10*r, vt[i].single ? (r + 1) % 4 : ((380 + 10*r) / 10) % 4);
      wait_cyc(420 + 10*r);
      chk("sb_empty_vec", sbq.size(), 0);
    end

    // bounce: row3/col3 contact for only 2 ticks
    keys = '0;
    do_reset();
    wait_cyc(71);
    keys = 16'h8000;
    wait_cyc(91);
    keys = '0;
    chk_row(99, 3);
    chk_row(100, 0);
    chk_row(110, 1);
    wait_cyc(150);
    chk("sb_empty_bounce", sbq.size(), 0);

    // two presses; a second key on the held row is ignored
    do_reset();
    wait_cyc(41);
    keys = 16'h0001;
    push_e.code = 4'h0; push_e.at = 70; sbq.push_back(push_e);
    wait_cyc(100);
    keys = 16'h0003;
    wait_cyc(141);
    keys = '0;
    chk_row(179, 0);
    wait_cyc(181);
    keys = 16'h0040;
    push_e.code = 4'h6; push_e.at = 210; sbq.push_back(push_e);
    chk_row(185, 1);
    wait_cyc(300);
    keys = '0;
    wait_cyc(400);
    chk("sb_empty_two", sbq.size(), 0);

    // reset during debounce of row2/col2, key kept held across reset
    do_reset();
    wait_cyc(61);
    keys = 16'h0400;
    wait_cyc(85);
    nrst = 1'b0;
    repeat (5) @(negedge clk);
    nrst = 1'b1;
    push_e.code = 4'hA; push_e.at = 50; sbq.push_back(push_e);
    chk_row(25, 2);
    wait_cyc(120);
    keys = '0;
    wait_cyc(200);
    chk("sb_empty_abort", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
